// File: rtl/gpio_regfile_bridge.sv
// Command decoder, control/status register file and sample capture buffer
// sitting between the MicroBlaze GPIO word pair and the DSP datapath.
module gpio_regfile_bridge #(
  parameter int NB_GPIOS = 32,
  parameter int NB_DATA  = 16,
  parameter int NB_ADDR  = 7,
  parameter int N_CTRL   = 8,
  parameter int N_STAT   = 4,
  parameter int DEPTH    = 256,
  parameter int NB_PTR   = 8
) (
  input  logic                       clock,
  input  logic                       in_reset,
  input  logic [NB_GPIOS-1:0]        in_gpo,
  output logic [NB_GPIOS-1:0]        out_gpi,
  output logic [N_CTRL*NB_DATA-1:0]  out_ctrl,
  input  logic [N_STAT*NB_DATA-1:0]  in_status,
  input  logic [NB_DATA-1:0]         in_cap_data,
  input  logic                       in_cap_valid
);

  localparam logic [7:0] OP_WR_CTRL  = 8'h01;
  localparam logic [7:0] OP_RD_REG   = 8'h02;
  localparam logic [7:0] OP_CAP_START = 8'h03;
  localparam logic [7:0] OP_CAP_READ = 8'h04;
  localparam logic [7:0] OP_CLEAR    = 8'h05;
  localparam int CTRL_AW = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
  localparam int STAT_AW = (N_STAT > 1) ? $clog2(N_STAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_reg, state_next;

  logic [NB_GPIOS-1:0] gpo_q_reg;
  logic                strobe_qq_reg;
  logic                strobe_event;

  logic [7:0]          op_reg;
  logic [NB_ADDR-1:0]  addr_reg;
  logic [NB_DATA-1:0]  data_reg;

  logic [NB_DATA-1:0]  ctrl_reg [N_CTRL];
  logic [NB_DATA-1:0]  status_word [N_STAT];
  logic [NB_DATA-1:0]  mem [DEPTH];
  logic [NB_DATA-1:0]  mem_rd_reg;

  logic [NB_PTR-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic                cap_busy_reg, cap_full_reg;
  logic                cap_we;

  logic                ack_reg, err_reg;
  logic [NB_DATA-1:0]  resp_data_reg;
  logic [NB_DATA-1:0]  exec_data_reg, exec_data_next;
  logic                exec_err_reg, exec_err_next;
  logic                exec_mem_reg, exec_mem_next;

  logic                ctrl_we, cap_start, cap_clear, rd_adv;
  logic                addr_is_ctrl, addr_is_stat;
  logic [CTRL_AW-1:0]  ctrl_idx;
  logic [STAT_AW-1:0]  stat_idx;

  generate
    for (genvar gi = 0; gi < N_CTRL; gi++) begin : g_ctrl_out
      assign out_ctrl[gi*NB_DATA +: NB_DATA] = ctrl_reg[gi];
    end
    for (genvar gi = 0; gi < N_STAT; gi++) begin : g_stat_in
      assign status_word[gi] = in_status[gi*NB_DATA +: NB_DATA];
    end
  endgenerate

  // The GPIO pipeline keeps sampling through reset, so a strobe held high
  // across reset is not mistaken for a fresh rising edge afterwards.
  always_ff @(posedge clock) begin
    gpo_q_reg     <= in_gpo;
    strobe_qq_reg <= gpo_q_reg[31];
  end

  assign strobe_event = gpo_q_reg[31] & ~strobe_qq_reg;

  assign addr_is_ctrl = int'(addr_reg) < N_CTRL;
  assign addr_is_stat = !addr_is_ctrl && (int'(addr_reg) < N_CTRL + N_STAT);
  assign ctrl_idx     = addr_reg[CTRL_AW-1:0];
  assign stat_idx     = STAT_AW'(addr_reg - NB_ADDR'(N_CTRL));

  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ctrl_we        = 1'b0;
    cap_start      = 1'b0;
    cap_clear      = 1'b0;
    rd_adv         = 1'b0;
    exec_data_next = '0;
    exec_err_next  = 1'b0;
    exec_mem_next  = 1'b0;
    case (state_reg)
      IDLE: if (strobe_event) state_next = EXEC;
      EXEC: begin
        state_next = RESP;
        case (op_reg)
          OP_WR_CTRL: begin
            if (addr_is_ctrl) begin
              ctrl_we        = 1'b1;
              exec_data_next = data_reg;
            end else begin
              exec_err_next = 1'b1;
            end
          end
          OP_RD_REG: begin
            if (addr_is_ctrl)      exec_data_next = ctrl_reg[ctrl_idx];
            else if (addr_is_stat) exec_data_next = status_word[stat_idx];
            else                   exec_err_next  = 1'b1;
          end
          OP_CAP_START: cap_start = 1'b1;
          OP_CAP_READ: begin
            if (cap_full_reg) begin
              rd_adv        = 1'b1;
              exec_mem_next = 1'b1;
            end else begin
              exec_err_next = 1'b1;
            end
          end
          OP_CLEAR: cap_clear = 1'b1;
          default:  exec_err_next = 1'b1;
        endcase
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      op_reg        <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      exec_data_reg <= '0;
      exec_err_reg  <= 1'b0;
      exec_mem_reg  <= 1'b0;
      resp_data_reg <= '0;
      err_reg       <= 1'b0;
      ack_reg       <= 1'b0;
    end else begin
      if (state_reg == IDLE && strobe_event) begin
        op_reg   <= gpo_q_reg[30:23];
        addr_reg <= gpo_q_reg[16 +: NB_ADDR];
        data_reg <= gpo_q_reg[NB_DATA-1:0];
      end
      if (state_reg == EXEC) begin
        exec_data_reg <= exec_data_next;
        exec_err_reg  <= exec_err_next;
        exec_mem_reg  <= exec_mem_next;
      end
      if (state_reg == RESP) begin
        resp_data_reg <= exec_mem_reg ? mem_rd_reg : exec_data_reg;
        err_reg       <= exec_err_reg;
        ack_reg       <= ~ack_reg;
      end
    end
  end

  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      for (int i = 0; i < N_CTRL; i++) ctrl_reg[i] <= '0;
    end else if (cap_clear) begin
      for (int i = 0; i < N_CTRL; i++) ctrl_reg[i] <= '0;
    end else if (ctrl_we) begin
      ctrl_reg[ctrl_idx] <= data_reg;
    end
  end

  // A sample arriving in the same cycle as a restart or clear is discarded.
  assign cap_we = cap_busy_reg & in_cap_valid & ~cap_start & ~cap_clear;

  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      cap_busy_reg <= 1'b0;
      cap_full_reg <= 1'b0;
    end else if (cap_clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      cap_busy_reg <= 1'b0;
      cap_full_reg <= 1'b0;
    end else if (cap_start) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      cap_busy_reg <= 1'b1;
      cap_full_reg <= 1'b0;
    end else begin
      if (cap_we) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (&wr_ptr_reg) begin
          cap_busy_reg <= 1'b0;
          cap_full_reg <= 1'b1;
        end
      end
      if (rd_adv) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Capture storage has no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (cap_we) mem[wr_ptr_reg] <= in_cap_data;
    mem_rd_reg <= mem[rd_ptr_reg];
  end

  assign out_gpi = {ack_reg, cap_full_reg, cap_busy_reg, err_reg, 12'h000, 16'(resp_data_reg)};

endmodule
